// File: rtl/mac_pkg.sv
// Shared constants and tag type for the mantissa multiply datapath.
package mac_pkg;

    localparam int unsigned MANT_W      = 24;
    localparam int unsigned PROD_W      = 2 * MANT_W;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef logic [ID_W_DEF-1:0] id_t;

endpackage

// File: rtl/Int_Multiplier.sv
// Purely combinational unsigned W x W -> 2W integer multiplier.
module Int_Multiplier #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product
);

    localparam int unsigned PW = 2 * W;

    // Full-width product, no truncation.
    assign product = PW'(a) * PW'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan ptr, ptr+1, ... with modulo-N wrap and stop at the first request.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mant_mul_arbiter.sv
// Round-robin sharing of one 24x24 mantissa multiplier with a two-stage pipeline.
module mant_mul_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*MANT_W-1:0] req_a,
    input  logic [NUM_REQ*MANT_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_product,
    input  logic                      rsp_ready
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               adv;
    logic               transfer;
    logic [MANT_W-1:0]  sel_a;
    logic [MANT_W-1:0]  sel_b;

    logic               s1_valid;
    logic [MANT_W-1:0]  s1_a;
    logic [MANT_W-1:0]  s1_b;
    logic [ID_W-1:0]    s1_id;
    logic [PROD_W-1:0]  mul_p;

    logic               s2_valid;
    logic [PROD_W-1:0]  s2_product;
    logic [ID_W-1:0]    s2_id;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    Int_Multiplier #(
        .W (MANT_W)
    ) u_mul (
        .a       (s1_a),
        .b       (s1_b),
        .product (mul_p)
    );

    // Pipeline moves whenever S2 is empty or its product is being taken.
    always_comb begin
        adv       = !s2_valid || rsp_ready;
        req_ready = adv ? grant : '0;
        transfer  = adv && (|grant);
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*MANT_W +: MANT_W];
                sel_b = req_b[i*MANT_W +: MANT_W];
            end
        end
    end

    // Priority pointer moves past the requester just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + ID_W'(1);
            end
        end
    end

    // S1 operand stage and S2 product stage; both freeze under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            s2_valid   <= 1'b0;
            s2_product <= '0;
            s2_id      <= '0;
        end else if (adv) begin
            s2_valid   <= s1_valid;
            s2_product <= mul_p;
            s2_id      <= s1_id;
            s1_valid   <= transfer;
            if (transfer) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= grant_idx;
            end
        end
    end

    assign rsp_valid   = s2_valid;
    assign rsp_id      = s2_id;
    assign rsp_product = s2_product;

endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed self-checking bench for mant_mul_arbiter (NUM_REQ = 4).
module tb_mant_mul_arbiter;

    localparam int unsigned N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*24-1:0] req_a;
    logic [N*24-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [47:0]   rsp_product;
    logic          rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    mant_mul_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [23:0] a, input logic [23:0] b);
        req_a[idx*24 +: 24] = a;
        req_b[idx*24 +: 24] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single request from a lone requester, checked through to its response.
    task automatic send_one(input string tag, input int idx, input logic [23:0] a,
                            input logic [23:0] b, input logic [47:0] exp);
        set_op(idx, a, b);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << idx));
        tick();
        req_valid = '0;
        chk({tag, "_lat1"}, 64'(rsp_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_id"}, 64'(rsp_id), 64'(idx));
        chk({tag, "_prod"}, 64'(rsp_product), 64'(exp));
        tick();
        chk({tag, "_once"}, 64'(rsp_valid), 64'd0);
    endtask

    logic [23:0] a3 [6];
    logic [23:0] b3 [6];
    logic [47:0] e3 [6];

    initial begin
        int sent;
        int got;
        int stalls;
        logic acc;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        a3 = '{24'h000003, 24'h000005, 24'h000007, 24'h00000B, 24'h00000D, 24'h000011};
        b3 = '{24'h000010, 24'h000100, 24'h001000, 24'h010000, 24'h100000, 24'h000001};
        e3 = '{48'h30, 48'h500, 48'h7000, 48'hB0000, 48'hD00000, 48'h11};

        // Reset values.
        do_reset();
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_prod", 64'(rsp_product), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Lone requester 2 with maximal operands.
        send_one("max", 2, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);

        // All four requesters continuously valid: strict rotation 0,1,2,3,...
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_op(i, 24'(24'h000100 * (i + 1)), 24'(24'h000003 + i));
        end
        req_valid = 4'b1111;
        for (int k = 0; k <= 10; k++) begin
            if (k == 8) begin
                req_valid = '0;
            end
            #1;
            if (k < 8) begin
                chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            end
            if (k >= 2 && k <= 9) begin
                chk($sformatf("rr_valid%0d", k), 64'(rsp_valid), 64'd1);
                chk($sformatf("rr_id%0d", k), 64'(rsp_id), 64'((k - 2) % 4));
                case ((k - 2) % 4)
                    0: chk($sformatf("rr_prod%0d", k), 64'(rsp_product), 64'h300);
                    1: chk($sformatf("rr_prod%0d", k), 64'(rsp_product), 64'h800);
                    2: chk($sformatf("rr_prod%0d", k), 64'(rsp_product), 64'hF00);
                    default: chk($sformatf("rr_prod%0d", k), 64'(rsp_product), 64'h1800);
                endcase
            end else begin
                chk($sformatf("rr_idle%0d", k), 64'(rsp_valid), 64'd0);
            end
            @(posedge clk);
            #1;
        end

        // Stream from requester 0 with five cycles of backpressure.
        sent   = 0;
        got    = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            rsp_ready = !(cyc >= 4 && cyc < 9);
            req_valid = (sent < 6) ? 4'b0001 : 4'b0000;
            if (sent < 6) begin
                set_op(0, a3[sent], b3[sent]);
            end
            #1;
            if (rsp_valid && !rsp_ready) begin
                stalls++;
                chk("bp_ready", 64'(req_ready), 64'd0);
                chk("bp_id", 64'(rsp_id), 64'd0);
                if (got < 6) begin
                    chk("bp_hold", 64'(rsp_product), 64'(e3[got]));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (got < 6) begin
                    chk("bp_id", 64'(rsp_id), 64'd0);
                    chk("bp_prod", 64'(rsp_product), 64'(e3[got]));
                end
                got++;
            end
            acc = req_valid[0] && req_ready[0];
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
            end
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        chk("bp_count", 64'(got), 64'd6);
        chk("bp_stalls", 64'(stalls), 64'd5);

        // Corner operands through requester 1.
        send_one("c800", 1, 24'h800000, 24'h800000, 48'h400000000000);
        send_one("czero", 1, 24'h000000, 24'hABCDEF, 48'h0);
        send_one("cone", 1, 24'h000001, 24'h123456, 48'h000000123456);

        // Pointer now 2: requesters 1 and 3 -> 3 first, wrap, then 1, then 3.
        set_op(1, 24'd2, 24'd3);
        set_op(3, 24'h10, 24'h10);
        req_valid = 4'b1010;
        #1;
        chk("wrap_g0", 64'(req_ready), 64'(4'b1000));
        tick();
        chk("wrap_g1", 64'(req_ready), 64'(4'b0010));
        chk("wrap_v1", 64'(rsp_valid), 64'd0);
        tick();
        chk("wrap_g2", 64'(req_ready), 64'(4'b1000));
        chk("wrap_id2", 64'(rsp_id), 64'd3);
        chk("wrap_p2", 64'(rsp_product), 64'h100);
        tick();
        req_valid = '0;
        chk("wrap_id3", 64'(rsp_id), 64'd1);
        chk("wrap_p3", 64'(rsp_product), 64'd6);
        tick();
        chk("wrap_id4", 64'(rsp_id), 64'd3);
        chk("wrap_v4", 64'(rsp_valid), 64'd1);
        tick();
        chk("wrap_v5", 64'(rsp_valid), 64'd0);

        // Reset with two products in flight.
        set_op(0, 24'd5, 24'd5);
        set_op(1, 24'd6, 24'd6);
        req_valid = 4'b0011;
        tick();
        tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mrst_v%0d", i), 64'(rsp_valid), 64'd0);
            tick();
        end
        set_op(1, 24'd7, 24'd9);
        set_op(3, 24'd1, 24'd1);
        req_valid = 4'b1010;
        #1;
        chk("mrst_ptr", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        chk("mrst_lat", 64'(rsp_valid), 64'd0);
        tick();
        chk("mrst_valid", 64'(rsp_valid), 64'd1);
        chk("mrst_id", 64'(rsp_id), 64'd1);
        chk("mrst_prod", 64'(rsp_product), 64'h3F);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mant_mul_arbiter.md
# mant_mul_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one 24×24 integer mantissa multiplier (`Int_Multiplier`) among `NUM_REQ` requesters, such as the processing elements of one systolic-array row.
- Each requester presents a 24-bit operand pair with a valid/ready handshake.
- The block registers the granted operands, drives the shared multiplier, registers the 48-bit product, and returns it tagged with the requester index.
- The whole pipeline stalls under output backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag. Derived; do not override.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  per-requester operand-pair valid.
- `req_a`  in  `NUM_REQ*24`  packed multiplicands; requester i occupies bits [24i+23:24i].
- `req_b`  in  `NUM_REQ*24`  packed multipliers, same packing as `req_a`.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high per cycle.
- `rsp_valid`  out  1  product valid.
- `rsp_id`  out  `ID_W`  index of the requester that owns the product.
- `rsp_product`  out  48  unsigned product `req_a` × `req_b`.
- `rsp_ready`  in  1  consumer accepts the response.

## Operation
- Pipeline registers:
  - Stage S1 holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - The shared multiplier is purely combinational on `s1_a` and `s1_b`.
  - Stage S2 holds `s2_valid`, `s2_product`, `s2_id`. S2 drives the `rsp_*` outputs directly.
- Advance signal: `adv = !s2_valid || rsp_ready`.
- When `adv` is high at a clock edge:
  - S2 loads from S1: valid, the multiplier output, and the id.
  - S1 loads the granted request. If no request is granted, `s1_valid` becomes 0.
- When `adv` is low, S1 and S2 hold all their contents.
- Arbitration (round-robin):
  - Pointer `rr_ptr` (`ID_W` bits) marks the highest-priority requester.
  - The grant goes to the first asserted `req_valid` scanning `rr_ptr`, `rr_ptr`+1, … with modulo-`NUM_REQ` wrap.
- `req_ready[i] = adv && grant[i]`. A transfer occurs when `req_valid[i] && req_ready[i]`.
- On a transfer, `rr_ptr` becomes (granted index + 1) mod `NUM_REQ`. Otherwise `rr_ptr` holds.
- `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Requesters keep `req_valid` asserted and their operands stable until accepted. The block does not check this.
- Arithmetic: full unsigned 48-bit product with no truncation or rounding. Normalisation belongs to the FP32 datapath downstream.

## Timing
- Reset values: `s1_valid`=0, `s2_valid`=0, `rr_ptr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `req_ready`=0.
- The data registers also clear on reset so that outputs are deterministic.
- Latency: a request accepted at edge T gives `rsp_valid`=1 in the cycle after edge T+1, i.e. two edges from acceptance.
- Throughput: one product per cycle while `rsp_ready` stays high.
- Backpressure: while `rsp_valid && !rsp_ready`:
  - all `req_ready` are 0;
  - `rsp_*` are stable;
  - S1 is preserved, with no loss or duplication.
- Bubble fill: when `s2_valid`=0, `adv`=1, even if `rsp_ready`=0.
- Simultaneous requests: exactly one grant per cycle. After a grant to index k, all other pending requesters are served before k is served again.
- Wrap: when `rr_ptr`=`NUM_REQ`-1 and the grant goes to `NUM_REQ`-1, the next `rr_ptr` is 0.
- Reset mid-operation: all in-flight products are discarded and no response is emitted for them. Requesters must re-present.

## Structure
- Shared package `mac_pkg` holds `MANT_W`=24 and `PROD_W`=48 constants and an `id_t` typedef for the tag, derived from `NUM_REQ`.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `req`, `ptr`;
  - one-hot `grant` output and encoded `grant_idx` output;
  - purely combinational.
- `rr_ptr` register, the pipeline registers, and the `Int_Multiplier` instance live in `mant_mul_arbiter`.

## Test plan
- Reset, then requester 2 alone presents `a`=0xFFFFFF, `b`=0xFFFFFF with `rsp_ready`=1 → two edges later `rsp_valid`=1, `rsp_id`=2, `rsp_product`=0xFFFFFE000001, asserted for exactly one cycle.
- All four requesters valid continuously with `rsp_ready`=1 → grants in order 0,1,2,3,0,…, one response per cycle, and products match `a`×`b` for each tag.
- Stream from requester 0, then hold `rsp_ready`=0 for 5 cycles → `rsp_*` frozen, `req_ready`=0, and after release the remaining products arrive in order with none lost or duplicated.
- Corner operands (`a`=0x800000, `b`=0x800000 → 0x400000000000; `a`=0, `b`=0xABCDEF → 0; `a`=1, `b`=0x123456 → 0x000000123456) → exact products.
- Requesters 1 and 3 valid and `rr_ptr`=2 → requester 3 is granted first, then 1, then the pointer wraps.
- Assert `rst` for one cycle with two products in flight → no `rsp_valid` afterwards until a new request is accepted; `rr_ptr` returns to 0.
